// File: rtl/mmio_periph_bank.sv
// Memory-mapped UI peripheral bank: HEX/LEDR outputs, debounced KEY/SW inputs,
// sticky key-press capture and a prescaled interval timer with overflow flag.
module mmio_periph_bank #(
  parameter int DBITS      = 32,
  parameter int N_HEX      = 6,
  parameter int N_LEDR     = 10,
  parameter int N_KEYS     = 4,
  parameter int N_SW       = 10,
  parameter int DEB_CYCLES = 500000,
  parameter int PRESCALE   = 50000,
  parameter logic [DBITS-1:0] ADDR_HEX  = 32'hF0000000,
  parameter logic [DBITS-1:0] ADDR_LEDR = 32'hF0000004,
  parameter logic [DBITS-1:0] ADDR_KEY  = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_SW   = 32'hF0000014,
  parameter logic [DBITS-1:0] ADDR_KCAP = 32'hF0000018,
  parameter logic [DBITS-1:0] ADDR_TCNT = 32'hF0000020,
  parameter logic [DBITS-1:0] ADDR_TLIM = 32'hF0000024,
  parameter logic [DBITS-1:0] ADDR_TCTL = 32'hF0000028
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DBITS-1:0]     addr,
  input  logic [DBITS-1:0]     wdata,
  input  logic                 we,
  output logic [DBITS-1:0]     rdata,
  output logic                 hit,
  input  logic [N_KEYS-1:0]    KEY,
  input  logic [N_SW-1:0]      SW,
  output logic [N_LEDR-1:0]    LEDR,
  output logic [7*N_HEX-1:0]   HEX
);

  localparam int NB = N_KEYS + N_SW;
  localparam int HB = 4 * N_HEX;
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int PW = $clog2(PRESCALE + 1);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Keys are inverted before synchronising so every debounced bit means "active".
  logic [NB-1:0]     sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NB-1:0]     deb_q, deb_d, deb_prev_q, deb_prev_d;
  logic [CW-1:0]     c_q [NB];
  logic [CW-1:0]     c_d [NB];
  logic [HB-1:0]     hex_q, hex_d;
  logic [N_LEDR-1:0] ledr_q, ledr_d;
  logic [N_KEYS-1:0] kcap_q, kcap_d;
  logic [DBITS-1:0]  tcnt_q, tcnt_d, tlim_q, tlim_d;
  logic              en_q, en_d, ovf_q, ovf_d;
  logic [PW-1:0]     p_q, p_d;

  logic wr_hex, wr_ledr, wr_kcap, wr_tcnt, wr_tlim, wr_tctl;
  logic tick, ovf_set;

  assign wr_hex  = we && (addr == ADDR_HEX);
  assign wr_ledr = we && (addr == ADDR_LEDR);
  assign wr_kcap = we && (addr == ADDR_KCAP);
  assign wr_tcnt = we && (addr == ADDR_TCNT);
  assign wr_tlim = we && (addr == ADDR_TLIM);
  assign wr_tctl = we && (addr == ADDR_TCTL);
  assign tick    = en_q && (p_q == PW'(PRESCALE - 1));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    sync1_d    = {SW, ~KEY};
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    c_d        = c_q;
    for (int b = 0; b < NB; b++) begin
      if (sync2_q[b] == deb_q[b]) begin
        c_d[b] = '0;
      end else if (c_q[b] == CW'(DEB_CYCLES - 1)) begin
        deb_d[b] = sync2_q[b];
        c_d[b]   = '0;
      end else begin
        c_d[b] = c_q[b] + CW'(1);
      end
    end

    hex_d  = wr_hex  ? wdata[HB-1:0]     : hex_q;
    ledr_d = wr_ledr ? wdata[N_LEDR-1:0] : ledr_q;
    tlim_d = wr_tlim ? wdata             : tlim_q;
    // A capture on the rising edge of deb wins over a W1C in the same cycle.
    kcap_d = (kcap_q & ~(wr_kcap ? wdata[N_KEYS-1:0] : '0))
           | (deb_q[N_KEYS-1:0] & ~deb_prev_q[N_KEYS-1:0]);

    en_d = wr_tctl ? wdata[0] : en_q;
    if (en_q && en_d) p_d = (p_q == PW'(PRESCALE - 1)) ? '0 : p_q + PW'(1);
    else              p_d = '0;

    ovf_set = 1'b0;
    tcnt_d  = tcnt_q;
    if (wr_tcnt) begin
      tcnt_d = wdata;
    end else if (tick) begin
      if ((tlim_q != '0 && tcnt_q == tlim_q - DBITS'(1)) || (tlim_q == '0 && &tcnt_q)) begin
        tcnt_d  = '0;
        ovf_set = 1'b1;
      end else begin
        tcnt_d = tcnt_q + DBITS'(1);
      end
    end
    ovf_d = (ovf_q & ~(wr_tctl & wdata[1])) | ovf_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      // NOTE: the per-bit counter array is plain flops, so it is reset like any
      // other state; a reset mid-debounce must not leave a half-counted bounce.
      for (int b = 0; b < NB; b++) c_q[b] <= '0;
      hex_q      <= '0;
      ledr_q     <= '0;
      kcap_q     <= '0;
      tcnt_q     <= '0;
      tlim_q     <= '0;
      en_q       <= 1'b0;
      ovf_q      <= 1'b0;
      p_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      c_q        <= c_d;
      hex_q      <= hex_d;
      ledr_q     <= ledr_d;
      kcap_q     <= kcap_d;
      tcnt_q     <= tcnt_d;
      tlim_q     <= tlim_d;
      en_q       <= en_d;
      ovf_q      <= ovf_d;
      p_q        <= p_d;
    end
  end

  always_comb begin
    rdata = '0;
    hit   = 1'b1;
    case (addr)
      ADDR_HEX:  rdata[HB-1:0]     = hex_q;
      ADDR_LEDR: rdata[N_LEDR-1:0] = ledr_q;
      ADDR_KEY:  rdata[N_KEYS-1:0] = deb_q[N_KEYS-1:0];
      ADDR_SW:   rdata[N_SW-1:0]   = deb_q[NB-1:N_KEYS];
      ADDR_KCAP: rdata[N_KEYS-1:0] = kcap_q;
      ADDR_TCNT: rdata             = tcnt_q;
      ADDR_TLIM: rdata             = tlim_q;
      ADDR_TCTL: rdata[1:0]        = {ovf_q, en_q};
      default:   hit               = 1'b0;
    endcase
  end

  assign LEDR = ledr_q;

  for (genvar g = 0; g < N_HEX; g++) begin : g_hex
    assign HEX[7*g +: 7] = hex7(hex_q[4*g +: 4]);
  end

endmodule

// File: doc/mmio_periph_bank.md
# mmio_periph_bank

The memory-mapped peripheral bank replaces the fixed four-device UI path between the processor's load/store address decode and the board I/O. It is parametrised in HEX digit count, LED, key and switch widths. It adds switch and key debouncing, sticky key-press capture and a prescaled interval timer with an overflow flag. It sits on the processor data port: the `ioAddr` / store-data / store-enable triple comes in, and a read word goes out to the register-file write-back mux.

## Interface
- DBITS, 32: bus data and address width.
- N_HEX, 6: number of 7-segment digits; each digit is driven from one 4-bit nibble of the HEX register.
- N_LEDR, 10: LEDR width.
- N_KEYS, 4: KEY width.
- N_SW, 10: SW width.
- DEB_CYCLES, 500000: consecutive stable cycles required before a debounced value changes (minimum 1).
- PRESCALE, 50000: clk cycles per timer tick (minimum 1).
- ADDR_HEX / ADDR_LEDR / ADDR_KEY / ADDR_SW, 32'hF0000000 / F0000004 / F0000010 / F0000014: register addresses.
- ADDR_KCAP / ADDR_TCNT / ADDR_TLIM / ADDR_TCTL, 32'hF0000018 / F0000020 / F0000024 / F0000028: register addresses.
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- addr  in  DBITS  byte address; full-width compare, no partial decode.
- wdata  in  DBITS  store data.
- we  in  1  store strobe; one write per cycle.
- rdata  out  DBITS  combinational read of the register at `addr`.
- hit  out  1  combinational; high when `addr` matches any register.
- KEY  in  N_KEYS  raw board keys, active-low (pressed = 0).
- SW  in  N_SW  raw board switches.
- LEDR  out  N_LEDR  registered LED outputs.
- HEX  out  7*N_HEX  active-low segments; digit i occupies bits [7i+6:7i], segment order g..a.

## Operation
- HEX (RW): holds 4*N_HEX bits; reads return them zero-extended. Nibble i drives digit i through a hex-to-7-seg decode: 0 → 7'b1000000, F → 7'b0001110.
- LEDR (RW): holds N_LEDR bits and drives the LEDR port directly.
- KEY (RO): returns the debounced pressed vector. Bit j = 1 means key j is held.
- SW (RO): returns the debounced switch vector.
- Debounce applies per bit to every KEY and SW bit:
  - The raw input passes through a 2-FF synchroniser to give s.
  - Counter c clears whenever s == deb.
  - Otherwise c increments.
  - When s != deb and c == DEB_CYCLES-1: deb ← s and c ← 0.
- KCAP (RW1C), per key bit:
  - A 0→1 transition of debounced pressed sets the bit.
  - Writing 1 clears the bit; writing 0 leaves it unchanged.
  - A set and a clear in the same cycle leave the bit set.
- TCTL: bit0 EN (RW), bit1 OVF (RW1C); all other bits read 0.
- Prescaler p counts 0..PRESCALE-1 while EN = 1. It is held at 0 while EN = 0, and clears on EN 1→0.
- A tick occurs on the cycle p == PRESCALE-1.
- On a tick, with TLIM != 0 and TCNT == TLIM-1: TCNT ← 0 and OVF ← 1.
- On a tick, with TLIM == 0 and TCNT == all-ones: TCNT wraps to 0 and OVF ← 1.
- On any other tick: TCNT ← TCNT+1.
- A write to TCNT loads wdata and takes priority over a tick in the same cycle; p is unaffected.
- A write to TLIM takes effect from the next tick.
- OVF: set-on-overflow beats a W1C write in the same cycle.
- Writes to KEY, SW or an unmapped address are ignored. Reads of an unmapped address return 0 with hit = 0.

## Timing
- Reads are zero-latency (combinational `rdata`) and reflect register state as of the last clock edge.
- Writes update the register on the edge where `we` = 1. The new value is visible to a read and on LEDR/HEX in the following cycle.
- Debounce latency: the raw input changes before edge 1. s changes at edge 2. deb changes at edge 2+DEB_CYCLES, provided s stays stable. Any bounce restarts c.
- KCAP sets on the edge after the edge where deb rises, i.e. one cycle after KEY reads pressed.
- Timer: with EN written at edge 0, the first tick is at edge PRESCALE, and TCNT steps every PRESCALE cycles after that.
- Reset (asynchronous, any time, including mid-debounce or mid-count):
  - HEX, LEDR, KCAP, TCNT, TLIM, TCTL, p, all c ← 0.
  - Synchronisers and deb for KEY ← 0 (not pressed).
  - Synchronisers and deb for SW ← 0.
  - Outputs during reset: LEDR = 0, HEX = all digits 7'b1000000.
- After reset release, an SW input already high appears through the normal debounce latency. No spurious KCAP is set.

## Test plan
- Reset/RW: assert reset_n = 0 → LEDR = 0 and HEX digits = 7'h40. Write LEDR 0x3FF, then HEX 0x00ABCDEF → next cycle LEDR = 0x3FF and digit 0 = F (7'b0001110). Read of F0000030 → 0 with hit = 0.
- Debounce (DEB_CYCLES = 4): set SW[3] high with a 2-cycle glitch low after 1 cycle → SW read stays 0 until 4 stable cycles after the glitch, then bit 3 = 1 exactly at edge 2+4 after the last change.
- Key capture: press KEY[1] (drive 0) and hold → KEY read = 0x2 after debounce, KCAP = 0x2 one cycle later. Write KCAP 0x2 → KCAP = 0. Write 0x2 on the same edge as a new press of KEY[1] → KCAP stays 0x2.
- Timer limit (PRESCALE = 2, TLIM = 3): write TCTL = 1 → TCNT sequence 1, 2, 0 at edges 2, 4, 6, and OVF = 1 after edge 6. W1C of OVF on a set cycle → OVF stays 1.
- Timer wrap and load (TLIM = 0): load TCNT 0xFFFFFFFF → next tick gives TCNT = 0 and OVF = 1. A TCNT write coinciding with a tick → the written value wins.
- Async reset mid-count: assert reset_n low between edges with TCNT = 5 and a pending debounce → all registers 0 immediately. After release, the timer stays idle until EN is written.
